// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the 4-digit BCD to binary converter.
// The optional BCD2BIN_DIGIT_CHECK_EN build uses dig_invalid().
package bcd2bin_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 14;
  localparam int DIG_W      = 4;
  localparam int LAST_IDX   = 3;

  function automatic logic dig_invalid(
    input logic [DIG_W-1:0] d
  );
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd2bin_mac10.sv
// Combinational multiply-by-ten and add step, truncated to BIN_W bits.
// The multiply is built from two shifts to avoid a multiplier.
import bcd2bin_pkg::*;

module bcd_mac10 (
  input  logic [BIN_W-1:0] acc,
  input  logic [DIG_W-1:0] digit,
  output logic [BIN_W-1:0] mac
);

  assign mac = (acc << 3) + (acc << 1) + BIN_W'(digit);

endmodule

// File: rtl/bcd2bin.sv
// Serial 4-digit BCD to 14-bit binary converter, one digit per cycle.
// Define BCD2BIN_DIGIT_CHECK_EN to flag digits above 9 through err.
import bcd2bin_pkg::*;

module bcd2bin (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIG_W-1:0] in0,
  input  logic [DIG_W-1:0] in1,
  input  logic [DIG_W-1:0] in2,
  input  logic [DIG_W-1:0] in3,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] bin,
  output logic             err
);

  state_t                          state;
  logic [NUM_DIGITS-1:0][DIG_W-1:0] dig;
  logic [1:0]                      cnt;
  logic [BIN_W-1:0]                acc;
  logic [BIN_W-1:0]                acc_nxt;
  logic                            bad;

  bcd_mac10 u_mac (
    .acc   (acc),
    .digit (dig[cnt]),
    .mac   (acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dig   <= '0;
      cnt   <= '0;
      acc   <= '0;
      bin   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            dig   <= {in3, in2, in1, in0};
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          acc <= acc_nxt;
          cnt <= cnt + 2'd1;
          if (cnt == 2'(LAST_IDX))
            state <= DONE;
        end
        DONE: begin
          bin   <= bad ? '0 : acc;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad <= 1'b0;
      err <= 1'b0;
    end else begin
      unique case (state)
        IDLE:    if (start) bad <= 1'b0;
        CONV:    bad <= bad | dig_invalid(dig[cnt]);
        DONE:    err <= bad;
        default: bad <= 1'b0;
      endcase
    end
  end
`else
  assign bad = 1'b0;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin.sv
// Directed bench for bcd2bin: vector table plus hand-written
// sequences for start hold-off, input change, reset abort, throughput.
module tb_bcd2bin;

  localparam bit CHK =
`ifdef BCD2BIN_DIGIT_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic        busy, done, err;
  logic [13:0] bin;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd2bin dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in0   (in0),
    .in1   (in1),
    .in2   (in2),
    .in3   (in3),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  typedef struct {
    logic [3:0]  d0, d1, d2, d3;
    logic [13:0] exp_bin;
    logic        exp_err;
    string       name;
  } vec_t;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] a, b, c, d);
    in0 = a; in1 = b; in2 = c; in3 = d;
  endtask

  // start sampled at edge N; samples i=0..6 follow edges N..N+6
  task automatic conv(input logic [3:0] a, b, c, d,
                      input logic [13:0] eb, input logic ee,
                      input string name);
    int bn, dn;
    bn = 0; dn = 0;
    set_in(a, b, c, d);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (busy) bn++;
      if (done) dn++;
      if (i == 5) begin
        chk({name, ".done"}, done, 1);
        chk({name, ".bin"}, bin, eb);
        chk({name, ".err"}, err, ee);
      end
      if (i == 6) begin
        chk({name, ".hold_bin"}, bin, eb);
        chk({name, ".hold_err"}, err, ee);
      end
      if (i < 6) step();
    end
    chk({name, ".busy_cycles"}, bn, 5);
    chk({name, ".done_count"}, dn, 1);
  endtask

  vec_t vecs[6];

  initial begin
    int dn, d1st, d2nd;

    vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 14'd1234, 1'b0, "v1234"};
    vecs[1] = '{4'd9, 4'd9, 4'd9, 4'd9, 14'd9999, 1'b0, "v9999"};
    vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 14'd0,    1'b0, "v0000"};
    vecs[3] = '{4'd5, 4'd0, 4'd0, 4'd1, 14'd5001, 1'b0, "v5001"};
    vecs[4] = '{4'd1, 4'd10, 4'd2, 4'd3,
                CHK ? 14'd0 : 14'd2023, CHK, "vbad"};
    vecs[5] = '{4'd8, 4'd0, 4'd6, 4'd9, 14'd8069, 1'b0, "v8069"};

    step();
    step();
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.bin", bin, 0);
    chk("rst.err", err, 0);
    rst_n = 1'b1;
    step();

    foreach (vecs[k])
      conv(vecs[k].d0, vecs[k].d1, vecs[k].d2, vecs[k].d3,
           vecs[k].exp_bin, vecs[k].exp_err, vecs[k].name);

    // start held through three CONV edges is ignored, not queued
    set_in(4'd0, 4'd0, 4'd4, 4'd2);
    start = 1'b1;
    step();
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) start = 1'b0;
      if (done) dn++;
      if (i == 5) begin
        chk("hold.done", done, 1);
        chk("hold.bin", bin, 42);
      end
      step();
    end
    chk("hold.done_count", dn, 1);
    conv(4'd3, 4'd0, 4'd0, 4'd9, 14'd3009, 1'b0, "after_hold");

    // inputs change one cycle after capture
    set_in(4'd5, 4'd6, 4'd7, 4'd8);
    start = 1'b1;
    step();
    start = 1'b0;
    set_in(4'd1, 4'd1, 4'd1, 4'd1);
    for (int i = 1; i <= 5; i++) step();
    chk("inchg.done", done, 1);
    chk("inchg.bin", bin, 5678);
    step();

    // continuous start: one result every 6 cycles
    set_in(4'd1, 4'd2, 4'd3, 4'd4);
    start = 1'b1;
    step();
    d1st = -1; d2nd = -1;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        if (d1st < 0) d1st = i;
        else if (d2nd < 0) d2nd = i;
      end
      if (i < 11) step();
    end
    start = 1'b0;
    chk("thru.first", d1st, 5);
    chk("thru.second", d2nd, 11);
    chk("thru.bin", bin, 1234);
    step();

    // reset during the third CONV cycle aborts the conversion
    set_in(4'd8, 4'd8, 4'd8, 4'd8);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.bin", bin, 0);
    chk("abort.err", err, 0);
    step();
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dn++;
      step();
    end
    chk("abort.no_done", dn, 0);
    conv(4'd0, 4'd0, 4'd0, 4'd7, 14'd7, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd2bin.md
BCD2BIN -- requirements
Module: bcd2bin

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; all other behaviour is synchronous to the clock's rising edge.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  conversion request, sampled in IDLE only.
REQ-005 in0  input  4  thousands BCD digit.
REQ-006 in1  input  4  hundreds BCD digit.
REQ-007 in2  input  4  tens BCD digit.
REQ-008 in3  input  4  units BCD digit.
REQ-009 busy  output  1  high while a conversion is in progress (CONV or DONE).
REQ-010 done  output  1  one-cycle pulse; bin and err are valid in that cycle.
REQ-011 bin  output  14  binary result, held until the next done.
REQ-012 err  output  1  invalid-digit flag, qualified by done.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CONV and DONE.
REQ-014 In IDLE with start=1, the block SHALL capture in0..in3 into internal registers, clear the accumulator and the 2-bit digit counter, and enter CONV.
REQ-015 In CONV, each cycle SHALL compute acc <= acc*10 + digit[cnt], with cnt=0 selecting in0 (MSD) and cnt=3 selecting in3; the block SHALL then increment cnt.
REQ-016 The block SHALL implement *10 as (acc<<3)+(acc<<1) in 14-bit arithmetic; results SHALL be truncated modulo 2^14.
REQ-017 After the CONV cycle with cnt=3, the block SHALL enter DONE; in DONE it SHALL load bin from acc, assert done for exactly one cycle, and return to IDLE.
REQ-018 Latency: with start sampled at edge N, done SHALL be high during the cycle following edge N+5; back-to-back throughput SHALL be one result per 6 cycles.
REQ-019 The block SHALL ignore start while busy=1 and SHALL NOT queue it.
REQ-020 Changes on in0..in3 after capture SHALL NOT affect the running conversion.
REQ-021 Valid digit inputs (each 0-9) SHALL yield bin in the range 0..9999 exactly; no overflow is possible.
REQ-022 The block SHALL hold bin and err stable outside the done cycle.

Reset
REQ-023 On rst_n=0, at any time including mid-conversion, the block SHALL force state=IDLE, cnt=0, acc=0, bin=0, err=0, busy=0 and done=0.
REQ-024 A conversion aborted by reset SHALL produce no done pulse; the first start after reset release SHALL be handled normally.

Configuration
REQ-025 The macro BCD2BIN_DIGIT_CHECK_EN SHALL control invalid-digit checking.
REQ-026 When BCD2BIN_DIGIT_CHECK_EN is defined, the block SHALL flag any captured digit >9 (sticky across the CONV cycles); in DONE it SHALL then drive err=1 and bin=0.
REQ-027 When BCD2BIN_DIGIT_CHECK_EN is undefined, err SHALL be tied to 0 and invalid digits SHALL pass through the arithmetic of REQ-016 unchecked.

Structure
REQ-028 Package bcd2bin_pkg SHALL hold the state enum (IDLE/CONV/DONE), the constants NUM_DIGITS=4, BIN_W=14 and DIG_W=4, and the constant LAST_IDX=3.
REQ-029 The block SHALL contain one combinational sub-module, bcd_mac10 (ports: acc[13:0], digit[3:0] -> acc*10+digit [13:0]).
REQ-030 The FSM, counter and registers SHALL reside in bcd2bin.

Verification
REQ-031 Digits 1,2,3,4 with a start pulse -> done exactly 6 cycles later with bin=1234 (0x4D2) and err=0.
REQ-032 Digits 9,9,9,9 -> bin=9999 (0x270F); digits 0,0,0,0 -> bin=0; busy high for exactly 5 cycles in each case.
REQ-033 A second start held high for 3 cycles during a conversion of 0,0,4,2 -> a single done with bin=42; the next start after IDLE converts normally.
REQ-034 Inputs changed from 5,6,7,8 to 1,1,1,1 one cycle after start -> bin=5678.
REQ-035 With the macro defined, digits 1,10,2,3 -> err=1 and bin=0 at done; with the macro undefined, the same stimulus -> err=0 and bin=2023 (1000+1000+20+3).
REQ-036 rst_n asserted during the third CONV cycle -> all outputs 0 immediately, no done pulse; a following start with 0,0,0,7 -> bin=7.
